// File: rtl/audio_dac_if.sv
// Synthesizer-to-DAC-serializer bundle: parallel stereo samples in, codec serial port and status out.
interface audio_dac_if #(
  parameter int AUD_BIT_DEPTH = 24
);
  logic [AUD_BIT_DEPTH-1:0] lsound_in;
  logic [AUD_BIT_DEPTH-1:0] rsound_in;
  logic                     sample_valid;
  logic                     clear_flags;
  logic                     AUD_BCLK;
  logic                     AUD_DACLRCK;
  logic                     AUD_DACDAT;
  logic                     frame_start;
  logic                     underrun;
  logic                     overrun;

  modport master (
    output lsound_in, rsound_in, sample_valid, clear_flags,
    input  AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start, underrun, overrun
  );

  modport slave (
    input  lsound_in, rsound_in, sample_valid, clear_flags,
    output AUD_BCLK, AUD_DACLRCK, AUD_DACDAT, frame_start, underrun, overrun
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// Stereo I2S / left-justified DAC serializer: BCLK/LRCK from AUDIO_CLK by division,
// double-buffered samples (holding register -> per-frame shift register) with underrun/overrun flags.
module audio_dac_serializer #(
  parameter int AUD_BIT_DEPTH = 24,
  parameter int BCLK_DIV      = 4,
  parameter int SLOT_BITS     = 32,
  parameter int FORMAT        = 0
) (
  input  logic       AUDIO_CLK,
  input  logic       reset,
  audio_dac_if.slave aud
);
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  // Zero bits below the LSB within a slot; I2S spends one slot bit before the MSB.
  localparam int PAD        = SLOT_BITS - AUD_BIT_DEPTH - ((FORMAT == 0) ? 1 : 0);

  logic [DIV_W-1:0]                div_q, div_d;
  logic [BIT_W-1:0]                bit_q, bit_d;
  logic                            bclk_q, bclk_d;
  logic                            lrck_q, lrck_d;
  logic                            dat_q, dat_d;
  logic [FRAME_BITS-1:0]           shift_q, shift_d;
  logic [1:0][AUD_BIT_DEPTH-1:0]   hold_q, hold_d;
  logic                            fresh_q, fresh_d;
  logic                            armed_q, armed_d;
  logic                            under_q, under_d;
  logic                            over_q, over_d;

  logic [1:0][AUD_BIT_DEPTH-1:0]   in_smp, load_smp;
  logic [1:0][SLOT_BITS-1:0]       slot_img;
  logic                            fall_en, load_en, set_under, set_over;

  // Channel 0 = left, channel 1 = right.
  assign in_smp  = {aud.rsound_in, aud.lsound_in};
  assign fall_en = (div_q == DIV_W'(BCLK_DIV - 1));
  assign load_en = fall_en && (bit_q == BIT_W'(FRAME_BITS - 1));

  for (genvar c = 0; c < 2; c++) begin : g_slot
    assign slot_img[c] = SLOT_BITS'(load_smp[c]) << PAD;
  end

  always_comb begin
    div_d     = fall_en ? '0 : div_q + DIV_W'(1);
    bclk_d    = (div_d >= DIV_W'(BCLK_DIV / 2));
    bit_d     = bit_q;
    lrck_d    = lrck_q;
    dat_d     = dat_q;
    shift_d   = shift_q;
    hold_d    = hold_q;
    fresh_d   = fresh_q;
    armed_d   = armed_q;
    load_smp  = '0;
    set_under = 1'b0;
    set_over  = 1'b0;

    if (aud.sample_valid) begin
      hold_d  = in_smp;
      armed_d = 1'b1;
    end

    if (load_en) begin
      fresh_d = 1'b0;
      if (aud.sample_valid)  load_smp = in_smp;
      else if (fresh_q)      load_smp = hold_q;
      else if (armed_q) begin
        load_smp  = hold_q;
        set_under = 1'b1;
      end
    end else if (aud.sample_valid) begin
      fresh_d  = 1'b1;
      set_over = fresh_q;
    end

    if (fall_en) begin
      bit_d  = load_en ? '0 : bit_q + BIT_W'(1);
      lrck_d = (bit_d >= BIT_W'(SLOT_BITS));
      if (load_en) begin
        shift_d = {slot_img[0], slot_img[1]};
        dat_d   = shift_d[FRAME_BITS-1];
      end else begin
        shift_d = shift_q << 1;
        dat_d   = shift_q[FRAME_BITS-2];
      end
    end

    under_d = (under_q & ~aud.clear_flags) | set_under;
    over_d  = (over_q  & ~aud.clear_flags) | set_over;
  end

  always_ff @(posedge AUDIO_CLK or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      bit_q   <= '0;
      bclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
      dat_q   <= 1'b0;
      shift_q <= '0;
      hold_q  <= '0;
      fresh_q <= 1'b0;
      armed_q <= 1'b0;
      under_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      bclk_q  <= bclk_d;
      lrck_q  <= lrck_d;
      dat_q   <= dat_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      fresh_q <= fresh_d;
      armed_q <= armed_d;
      under_q <= under_d;
      over_q  <= over_d;
    end
  end

  assign aud.AUD_BCLK    = bclk_q;
  assign aud.AUD_DACLRCK = lrck_q;
  assign aud.AUD_DACDAT  = dat_q;
  assign aud.frame_start = load_en;
  assign aud.underrun    = under_q;
  assign aud.overrun     = over_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Scoreboard bench: I2S and left-justified instances share stimulus; each frame is captured
// bit by bit and compared with the expected sample pushed when it was strobed.
module tb_audio_dac_serializer;
  localparam int D    = 24;
  localparam int SLOT = 32;

  typedef struct packed { logic [D-1:0] l; logic [D-1:0] r; } frame_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  audio_dac_if #(.AUD_BIT_DEPTH(D)) if0 ();
  audio_dac_if #(.AUD_BIT_DEPTH(D)) if1 ();

  audio_dac_serializer #(.AUD_BIT_DEPTH(D), .BCLK_DIV(4), .SLOT_BITS(SLOT), .FORMAT(0))
    u_dut0 (.AUDIO_CLK(clk), .reset(rst), .aud(if0));
  audio_dac_serializer #(.AUD_BIT_DEPTH(D), .BCLK_DIV(4), .SLOT_BITS(SLOT), .FORMAT(1))
    u_dut1 (.AUDIO_CLK(clk), .reset(rst), .aud(if1));

  frame_t       sb_q[$];
  logic [D-1:0] m_l, m_r;
  logic         m_fresh, m_armed, m_under, m_over;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic drive(input logic sv, input logic [D-1:0] l, input logic [D-1:0] r, input logic clr);
    if0.sample_valid = sv; if0.lsound_in = l; if0.rsound_in = r; if0.clear_flags = clr;
    if1.sample_valid = sv; if1.lsound_in = l; if1.rsound_in = r; if1.clear_flags = clr;
  endtask

  task automatic model_reset();
    m_l = '0; m_r = '0; m_fresh = 1'b0; m_armed = 1'b0; m_under = 1'b0; m_over = 1'b0;
    sb_q.delete();
  endtask

  // Reference behaviour of the holding register for the clock edge that follows the drive.
  task automatic model_edge(input logic sv, input logic [D-1:0] l, input logic [D-1:0] r,
                            input logic clr, input logic load);
    frame_t e;
    logic su, so;
    su = 1'b0; so = 1'b0; e = '0;
    if (load) begin
      if (sv) begin e.l = l; e.r = r; m_l = l; m_r = r; m_armed = 1'b1; end
      else if (m_fresh) begin e.l = m_l; e.r = m_r; end
      else if (m_armed) begin e.l = m_l; e.r = m_r; su = 1'b1; end
      m_fresh = 1'b0;
      sb_q.push_back(e);
    end else if (sv) begin
      so = m_fresh; m_l = l; m_r = r; m_fresh = 1'b1; m_armed = 1'b1;
    end
    m_under = (m_under && !clr) || su;
    m_over  = (m_over  && !clr) || so;
  endtask

  function automatic logic [2*SLOT-1:0] exp_frame(input frame_t e, input int fmt);
    logic [2*SLOT-1:0] v;
    logic [D-1:0]      s;
    int                kk;
    v = '0;
    for (int k = 0; k < 2*SLOT; k++) begin
      s  = (k < SLOT) ? e.l : e.r;
      kk = k % SLOT;
      if (fmt == 0) v[2*SLOT-1-k] = (kk >= 1 && kk <= D) ? s[D-kk] : 1'b0;
      else          v[2*SLOT-1-k] = (kk < D) ? s[D-1-kk] : 1'b0;
    end
    return v;
  endfunction

  task automatic check_flags(input string nm);
    n_tests++;
    if ({if0.underrun, if1.underrun, if0.overrun, if1.overrun} !== {m_under, m_under, m_over, m_over}) begin
      n_fail++;
      $display("FAIL %s flags got u0=%b u1=%b o0=%b o1=%b exp under=%b over=%b",
               nm, if0.underrun, if1.underrun, if0.overrun, if1.overrun, m_under, m_over);
    end
  endtask

  task automatic check_all_zero(input string nm);
    n_tests++;
    if ({if0.AUD_BCLK, if0.AUD_DACLRCK, if0.AUD_DACDAT, if0.frame_start, if0.underrun, if0.overrun,
         if1.AUD_BCLK, if1.AUD_DACLRCK, if1.AUD_DACDAT, if1.frame_start, if1.underrun, if1.overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL %s outputs got %b%b%b%b%b%b_%b%b%b%b%b%b exp all 0", nm,
               if0.AUD_BCLK, if0.AUD_DACLRCK, if0.AUD_DACDAT, if0.frame_start, if0.underrun, if0.overrun,
               if1.AUD_BCLK, if1.AUD_DACLRCK, if1.AUD_DACDAT, if1.frame_start, if1.underrun, if1.overrun);
    end
  endtask

  // Entered right after a reset release at a falling clock edge; ends on the frame_start cycle.
  task automatic wait_first_load(input string nm);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(if0.frame_start && if1.frame_start) && n < 1000);
    n_tests++;
    if (n + 1 !== 256) begin
      n_fail++;
      $display("FAIL %s first_load edges got %0d exp 256", nm, n + 1);
    end
    drive(1'b0, D'($urandom), D'($urandom), 1'b0);
    model_edge(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  // One full frame, starting just after the load edge; strobes/clear at cycle indices (-1 = none).
  task automatic run_frame(input string nm, input int s1, input logic [D-1:0] l1, input logic [D-1:0] r1,
                           input int s2, input logic [D-1:0] l2, input logic [D-1:0] r2, input int clr);
    frame_t            e;
    logic [2*SLOT-1:0] cap0, cap1, x0, x1;
    logic              p0, p1, sv, cb;
    logic [D-1:0]      l, r;
    int                bad_clk, bad_fs, bad_stab;
    bad_clk = 0; bad_fs = 0; bad_stab = 0; cap0 = '0; cap1 = '0; p0 = 1'b0; p1 = 1'b0;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL %s scoreboard empty", nm);
      e = '0;
    end else e = sb_q.pop_front();
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (i % 4 == 1) begin
        cap0[2*SLOT-1-i/4] = if0.AUD_DACDAT;
        cap1[2*SLOT-1-i/4] = if1.AUD_DACDAT;
      end
      if ({if0.AUD_BCLK, if1.AUD_BCLK} !== {2{i % 4 >= 2}}) bad_clk++;
      if ({if0.AUD_DACLRCK, if1.AUD_DACLRCK} !== {2{i >= 128}}) bad_clk++;
      if ({if0.frame_start, if1.frame_start} !== {2{i == 255}}) bad_fs++;
      if (i % 4 != 0 && (if0.AUD_DACDAT !== p0 || if1.AUD_DACDAT !== p1)) bad_stab++;
      p0 = if0.AUD_DACDAT; p1 = if1.AUD_DACDAT;
      if (i == 0 || i == 254) check_flags(nm);
      sv = (i == s1) || (i == s2);
      l  = (i == s2) ? l2 : (i == s1) ? l1 : D'($urandom);
      r  = (i == s2) ? r2 : (i == s1) ? r1 : D'($urandom);
      cb = (i == clr);
      drive(sv, l, r, cb);
      model_edge(sv, l, r, cb, i == 255);
    end
    x0 = exp_frame(e, 0);
    x1 = exp_frame(e, 1);
    n_tests += 5;
    if (cap0 !== x0) begin n_fail++; $display("FAIL %s data_i2s got=%h exp=%h", nm, cap0, x0); end
    if (cap1 !== x1) begin n_fail++; $display("FAIL %s data_lj got=%h exp=%h", nm, cap1, x1); end
    if (bad_clk !== 0) begin n_fail++; $display("FAIL %s bclk_lrck bad_cycles got=%0d exp 0", nm, bad_clk); end
    if (bad_fs !== 0) begin n_fail++; $display("FAIL %s frame_start bad_cycles got=%0d exp 0", nm, bad_fs); end
    if (bad_stab !== 0) begin n_fail++; $display("FAIL %s data_edge bad_cycles got=%0d exp 0", nm, bad_stab); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    drive(1'b0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    wait_first_load("reset_release");
  endtask

  task automatic test_idle();
    for (int f = 0; f < 3; f++) run_frame("idle", -1, '0, '0, -1, '0, '0, -1);
  endtask

  task automatic test_format();
    run_frame("fmt_strobe", 50, 24'hA5A5A5, 24'h800001, -1, '0, '0, -1);
    run_frame("fmt_data", -1, '0, '0, -1, '0, '0, -1);
  endtask

  task automatic test_underrun();
    run_frame("underrun_repeat", -1, '0, '0, -1, '0, '0, -1);
    run_frame("underrun_clear", -1, '0, '0, -1, '0, '0, 20);
    run_frame("underrun_again", -1, '0, '0, -1, '0, '0, 5);
  endtask

  task automatic test_overrun();
    run_frame("overrun_two", 30, 24'h111111, 24'h333333, 90, 24'h222222, 24'h444444, -1);
    run_frame("overrun_data", -1, '0, '0, -1, '0, '0, 10);
  endtask

  task automatic test_bypass();
    run_frame("bypass_strobe", 255, 24'h7FFFFF, 24'h000001, -1, '0, '0, 10);
    run_frame("bypass_data", -1, '0, '0, -1, '0, '0, -1);
  endtask

  task automatic test_reset_mid();
    frame_t e;
    if (sb_q.size() != 0) e = sb_q.pop_front();
    for (int i = 0; i <= 162; i++) begin
      @(negedge clk);
      drive(1'b0, D'($urandom), D'($urandom), 1'b0);
    end
    n_tests++;
    if ({if0.AUD_DACLRCK, if0.AUD_BCLK, if0.underrun, if1.AUD_DACLRCK, if1.AUD_BCLK, if1.underrun} !== 6'b111111) begin
      n_fail++;
      $display("FAIL pre_reset got lr/bclk/under %b%b%b %b%b%b exp 111 111", if0.AUD_DACLRCK, if0.AUD_BCLK,
               if0.underrun, if1.AUD_DACLRCK, if1.AUD_BCLK, if1.underrun);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("async_reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_first_load("mid_reset_release");
    run_frame("post_reset_silent", 100, 24'h123456, 24'hFEDCBA, -1, '0, '0, -1);
    run_frame("post_reset_data", -1, '0, '0, -1, '0, '0, -1);
  endtask

  initial begin
    test_reset();
    test_idle();
    test_format();
    test_underrun();
    test_overrun();
    test_bypass();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end
endmodule
